// File: rtl/gpio_cfg_pkg.sv
// gpio_cfg_pkg: shared word width, pad mode field layout and loader FSM states.
package gpio_cfg_pkg;

   localparam int CFG_W = 13;

   localparam int MGMT_EN_BIT = 0;
   localparam int OEB_BIT     = 1;
   localparam int DM_LSB      = 10;
   localparam int DM_MSB      = 12;

   localparam logic [2:0] DM_PULLDOWN = 3'b011;
   localparam logic [2:0] DM_PULLUP   = 3'b010;
   localparam logic [2:0] DM_INPUT    = 3'b001;
   localparam logic [2:0] DM_OUTPUT   = 3'b110;

   typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LOAD, FIN} cfg_state_e;

   function automatic logic [CFG_W-1:0] cfg_word(input logic [2:0] dm, input logic oeb,
                                                 input logic mgmt_en);
      logic [CFG_W-1:0] w;
      w = '0;
      w[DM_MSB:DM_LSB] = dm;
      w[OEB_BIT] = oeb;
      w[MGMT_EN_BIT] = mgmt_en;
      return w;
   endfunction

endpackage

// File: rtl/gpio_cfg_clkdiv.sv
// gpio_cfg_clkdiv: phase_end strobe on every CLK_DIV-th consecutive enabled cycle.
module gpio_cfg_clkdiv #(
   parameter int CLK_DIV = 2
) (
   input  logic clock,
   input  logic resetn,
   input  logic en,
   output logic phase_end
);

   localparam int CW = $clog2(CLK_DIV) + 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      phase_end = en && (cnt_q == LAST);
      cnt_d = (en && !phase_end) ? cnt_q + 1'b1 : '0;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end

endmodule

// File: rtl/gpio_cfg_serial_loader.sv
// gpio_cfg_serial_loader: per-pad config register file that shifts its image into the
// pad control daisy chain (farthest pad first, MSB first) and then strobes serial_load.
module gpio_cfg_serial_loader
   import gpio_cfg_pkg::*;
#(
   parameter int NUM_IO = 38,
   parameter int CLK_DIV = 2,
   parameter logic [CFG_W-1:0] CFG_DEFAULT = 13'h1803
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             cfg_we,
   input  logic [5:0]       cfg_addr,
   input  logic [CFG_W-1:0] cfg_wdata,
   output logic [CFG_W-1:0] cfg_rdata,
   output logic             cfg_wr_err,
   input  logic             xfer_start,
   output logic             busy,
   output logic             done,
   output logic             serial_clock,
   output logic             serial_data_out,
   output logic             serial_load
);

   localparam int BW = $clog2(CFG_W);
   localparam logic [5:0] NUM_IO_A = 6'(NUM_IO);
   localparam logic [5:0] LAST_PAD = 6'(NUM_IO - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(CFG_W - 1);

   logic [CFG_W-1:0] words_q [NUM_IO];
   logic [CFG_W-1:0] words_d [NUM_IO];
   cfg_state_e state_q, state_d;
   logic [5:0] pad_q, pad_d;
   logic [BW-1:0] bit_q, bit_d;
   logic busy_q, busy_d, done_q, done_d, wr_err_q, wr_err_d;
   logic sclk_q, sclk_d, sdo_q, sdo_d, load_q, load_d;
   logic wr_ok, phase_end, div_en, shift_entry;

   gpio_cfg_clkdiv #(.CLK_DIV(CLK_DIV)) u_clkdiv (
      .clock     (clock),
      .resetn    (resetn),
      .en        (div_en),
      .phase_end (phase_end)
   );

   assign div_en = (state_q == SHIFT_LO) || (state_q == SHIFT_HI) || (state_q == LOAD);
   assign wr_ok = cfg_we && (state_q == IDLE) && (cfg_addr < NUM_IO_A);
   assign cfg_rdata = (cfg_addr < NUM_IO_A) ? words_q[cfg_addr] : '0;

   always_comb begin
      for (int i = 0; i < NUM_IO; i++)
         words_d[i] = (wr_ok && cfg_addr == 6'(i)) ? cfg_wdata : words_q[i];
   end

   always_comb begin
      state_d = state_q;
      pad_d = pad_q;
      bit_d = bit_q;
      case (state_q)
         IDLE: if (xfer_start) begin
            state_d = SHIFT_LO;
            pad_d = LAST_PAD;
            bit_d = LAST_BIT;
         end
         SHIFT_LO: if (phase_end) state_d = SHIFT_HI;
         SHIFT_HI: if (phase_end) begin
            if (pad_q == '0 && bit_q == '0) state_d = LOAD;
            else begin
               state_d = SHIFT_LO;
               bit_d = (bit_q == '0) ? LAST_BIT : bit_q - 1'b1;
               pad_d = (bit_q == '0) ? pad_q - 1'b1 : pad_q;
            end
         end
         LOAD: if (phase_end) state_d = FIN;
         FIN: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Fetching from words_d lets a same-cycle IDLE write land in the first shifted bit.
   always_comb begin
      shift_entry = (state_d == SHIFT_LO) && (state_q != SHIFT_LO);
      sdo_d = shift_entry ? words_d[pad_d][bit_d] :
              (state_d == SHIFT_LO || state_d == SHIFT_HI) ? sdo_q : 1'b0;
      sclk_d = state_d == SHIFT_HI;
      load_d = state_d == LOAD;
      done_d = state_d == FIN;
      busy_d = state_d != IDLE;
      wr_err_d = cfg_we && !wr_ok;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NUM_IO; i++) words_q[i] <= CFG_DEFAULT;
         state_q <= IDLE;
         pad_q <= '0;
         bit_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         wr_err_q <= 1'b0;
         sclk_q <= 1'b0;
         sdo_q <= 1'b0;
         load_q <= 1'b0;
      end else begin
         words_q <= words_d;
         state_q <= state_d;
         pad_q <= pad_d;
         bit_q <= bit_d;
         busy_q <= busy_d;
         done_q <= done_d;
         wr_err_q <= wr_err_d;
         sclk_q <= sclk_d;
         sdo_q <= sdo_d;
         load_q <= load_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign cfg_wr_err = wr_err_q;
   assign serial_clock = sclk_q;
   assign serial_data_out = sdo_q;
   assign serial_load = load_q;

endmodule
